// File: rtl/tdm_serializer_pkg.sv
// Shared types and helpers for the TDM serializer: FSM state encoding and
// channel-index width sizing.
package tdm_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tdm_state_e;

    function automatic int ch_idx_width(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/tdm_serializer_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO; a write while full is accepted
// only when a read frees the head slot in the same cycle.
module frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tdm_serializer.sv
// Buffers parallel channel frames and replays them one channel per AXI-Stream beat;
// 2 cycles strobe-to-first-beat, input has no backpressure so a full FIFO drops frames.
module tdm_serializer
    import tdm_serializer_pkg::*;
#(
    parameter int CH_NUM     = 2,
    parameter int DATA_WIDTH = 34,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic                                clear_i,
    input  logic                                tvalid_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0]        tdata_i,
    output logic                                m_tvalid_o,
    input  logic                                m_tready_i,
    output logic [DATA_WIDTH-1:0]               m_tdata_o,
    output logic [ch_idx_width(CH_NUM)-1:0]     m_tuser_o,
    output logic                                m_tlast_o,
    output logic                                overflow_o,
    output logic [CNT_WIDTH-1:0]                drop_cnt_o
);

    localparam int                FW   = CH_NUM * DATA_WIDTH;
    localparam int                IDXW = ch_idx_width(CH_NUM);
    localparam logic [IDXW-1:0]   LAST = IDXW'(CH_NUM - 1);

    tdm_state_e       state_q;
    tdm_state_e       state_d;
    logic [IDXW-1:0]  idx_q;
    logic [FW-1:0]    shreg_q;
    logic             pop;
    logic             shift;
    logic             drop;
    logic [FW-1:0]    fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;

    frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_frame_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_en   (tvalid_i),
        .wr_data (tdata_i),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A pop on the last-channel handshake reloads the shift register with no bubble.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_tready_i) begin
                    if (idx_q == LAST) begin
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_tvalid_o = (state_q == SEND);
        m_tdata_o  = shreg_q[DATA_WIDTH-1:0];
        m_tuser_o  = idx_q;
        m_tlast_o  = (state_q == SEND) && (idx_q == LAST);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (pop) begin
            idx_q   <= '0;
            shreg_q <= fifo_rd_data;
        end else if (shift) begin
            idx_q   <= idx_q + IDXW'(1);
            shreg_q <= shreg_q >> DATA_WIDTH;
        end
    end

    assign drop = tvalid_i && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tdm_serializer.sv
// Directed bench for tdm_serializer: a frame-level queue model predicts every beat,
// the sticky overflow flag and the drop counter; hand literals pin the key cycles.
module tb_tdm_serializer;

    localparam int CH = 2;
    localparam int DW = 34;
    localparam int FD = 4;
    localparam int CW = 16;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             clear_i;
    logic             tvalid_i;
    logic [CH*DW-1:0] tdata_i;
    logic             m_tvalid_o;
    logic             m_tready_i;
    logic [DW-1:0]    m_tdata_o;
    logic [0:0]       m_tuser_o;
    logic             m_tlast_o;
    logic             overflow_o;
    logic [CW-1:0]    drop_cnt_o;

    always #5 clk_i = ~clk_i;

    tdm_serializer #(
        .CH_NUM     (CH),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clear_i    (clear_i),
        .tvalid_i   (tvalid_i),
        .tdata_i    (tdata_i),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tdata_o  (m_tdata_o),
        .m_tuser_o  (m_tuser_o),
        .m_tlast_o  (m_tlast_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic          exp_ovf = 1'b0;
    logic [CW-1:0] exp_cnt = '0;
    logic          tb_drop = 1'b0;
    logic          held    = 1'b0;
    beat_t         held_b;
    int            vec = 0;
    int            err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vec++;
        if (act !== expv) begin
            err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
        end
    endtask

    task automatic flag_fail(input string nm);
        vec++;
        err++;
        $display("FAIL %s", nm);
    endtask

    // Model: an accepted frame becomes CH beats in channel order; a dropped one bumps the counters.
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_cnt = '0;
        end else begin
            if (tvalid_i && !tb_drop)
                for (int k = 0; k < CH; k++)
                    exp_q.push_back('{d: tdata_i[k*DW +: DW], u: 1'(k), l: (k == CH-1)});
            if (clear_i) begin
                exp_ovf = 1'b0;
                exp_cnt = '0;
            end else if (tvalid_i && tb_drop) begin
                exp_ovf = 1'b1;
                if (exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
            end
        end
    end

    // Compare process: status every cycle, beat content on each handshake, stability while stalled.
    always @(negedge clk_i) begin
        beat_t cur;
        beat_t b;
        cur = '{d: m_tdata_o, u: m_tuser_o, l: m_tlast_o};
        if (!rstn_i) begin
            held = 1'b0;
        end else begin
            chk("overflow_o", 64'(overflow_o), 64'(exp_ovf));
            chk("drop_cnt_o", 64'(drop_cnt_o), 64'(exp_cnt));
            if (held && !m_tvalid_o) flag_fail("tvalid dropped without handshake");
            if (held && m_tvalid_o)  chk("stall_stable", 64'(cur), 64'(held_b));
            held = 1'b0;
            if (m_tvalid_o) begin
                if (m_tready_i) begin
                    if (exp_q.size() == 0) begin
                        flag_fail("unexpected beat");
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat", 64'(cur), 64'(b));
                    end
                end else begin
                    held   = 1'b1;
                    held_b = cur;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [CH*DW-1:0] d, input logic drop);
        tvalid_i = 1'b1;
        tdata_i  = d;
        tb_drop  = drop;
        tick();
        tvalid_i = 1'b0;
        tb_drop  = 1'b0;
    endtask

    function automatic logic [CH*DW-1:0] mkf(input int f);
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
        c0 = 34'h1_0000_0000 + 34'(f * 2);
        c1 = 34'h2_8000_0000 + 34'(f * 2 + 1);
        return {c1, c0};
    endfunction

    task automatic drain(input string nm, output int nlast);
        int budget;
        budget = 0;
        nlast  = 0;
        while ((exp_q.size() != 0 || m_tvalid_o) && budget < 60) begin
            @(negedge clk_i);
            if (m_tvalid_o && m_tready_i && m_tlast_o) nlast++;
            tick();
            budget++;
        end
        if (budget >= 60) flag_fail({nm, " drain timeout"});
    endtask

    initial begin
        logic [CH*DW-1:0] f;
        int nv, nl, first, lastc;

        rstn_i     = 1'b0;
        clear_i    = 1'b0;
        tvalid_i   = 1'b0;
        tdata_i    = '0;
        m_tready_i = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        chk("rst m_tvalid_o", 64'(m_tvalid_o), 64'd0);
        chk("rst m_tdata_o",  64'(m_tdata_o),  64'd0);
        chk("rst m_tuser_o",  64'(m_tuser_o),  64'd0);
        chk("rst m_tlast_o",  64'(m_tlast_o),  64'd0);
        chk("rst overflow_o", 64'(overflow_o), 64'd0);
        chk("rst drop_cnt_o", 64'(drop_cnt_o), 64'd0);
        tick();
        rstn_i = 1'b1;
        tick();

        // Single frame: first beat two edges after the strobe.
        m_tready_i = 1'b1;
        f = {34'h0_0000_BEEF, 34'h0_0000_1234};
        strobe(f, 1'b0);
        @(negedge clk_i);
        chk("lat E0 tvalid", 64'(m_tvalid_o), 64'd0);
        @(negedge clk_i);
        chk("b0 tvalid", 64'(m_tvalid_o), 64'd1);
        chk("b0 tdata",  64'(m_tdata_o),  64'h1234);
        chk("b0 tuser",  64'(m_tuser_o),  64'd0);
        chk("b0 tlast",  64'(m_tlast_o),  64'd0);
        @(negedge clk_i);
        chk("b1 tdata",  64'(m_tdata_o),  64'hBEEF);
        chk("b1 tuser",  64'(m_tuser_o),  64'd1);
        chk("b1 tlast",  64'(m_tlast_o),  64'd1);
        @(negedge clk_i);
        chk("after frame tvalid", 64'(m_tvalid_o), 64'd0);
        tick();

        // Back-to-back: strobe every other cycle for 8 frames.
        nv = 0; nl = 0; first = -1; lastc = -1;
        for (int c = 0; c < 22; c++) begin
            tvalid_i = ((c % 2) == 0) && (c < 16);
            tdata_i  = mkf(c / 2);
            @(negedge clk_i);
            if (m_tvalid_o) begin
                nv++;
                if (first < 0) first = c;
                lastc = c;
                if (m_tlast_o) nl++;
            end
            tick();
        end
        tvalid_i = 1'b0;
        chk("b2b beats", 64'(nv), 64'd16);
        chk("b2b tlast count", 64'(nl), 64'd8);
        chk("b2b contiguous span", 64'(lastc - first), 64'd15);
        chk("b2b overflow_o", 64'(overflow_o), 64'd0);

        // Backpressure: beat 0 held for 5 stalled cycles.
        m_tready_i = 1'b0;
        f = mkf(20);
        strobe(f, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp tvalid", 64'(m_tvalid_o), 64'd1);
            chk("bp tdata",  64'(m_tdata_o),  64'h1_0000_0028);
            tick();
        end
        m_tready_i = 1'b1;
        @(negedge clk_i);
        chk("bp b0 tdata", 64'(m_tdata_o), 64'h1_0000_0028);
        tick();
        @(negedge clk_i);
        chk("bp b1 tdata", 64'(m_tdata_o), 64'h2_8000_0029);
        chk("bp b1 tlast", 64'(m_tlast_o), 64'd1);
        tick();
        @(negedge clk_i);
        chk("bp end tvalid", 64'(m_tvalid_o), 64'd0);
        tick();

        // Overflow: 1 in the output register, 4 queued, the sixth dropped.
        m_tready_i = 1'b0;
        for (int i = 0; i < 6; i++) strobe(mkf(30 + i), (i == 5));
        @(negedge clk_i);
        chk("ovf overflow_o", 64'(overflow_o), 64'd1);
        chk("ovf drop_cnt_o", 64'(drop_cnt_o), 64'd1);
        tick();
        strobe(mkf(36), 1'b1);
        @(negedge clk_i);
        chk("ovf2 drop_cnt_o", 64'(drop_cnt_o), 64'd2);
        tick();
        clear_i = 1'b1;
        strobe(mkf(37), 1'b1);
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("clr overflow_o", 64'(overflow_o), 64'd0);
        chk("clr drop_cnt_o", 64'(drop_cnt_o), 64'd0);
        tick();
        m_tready_i = 1'b1;
        drain("ovf", nl);
        chk("ovf frames out", 64'(nl), 64'd5);

        // Reset mid-frame with two frames queued.
        m_tready_i = 1'b0;
        for (int i = 0; i < 3; i++) strobe(mkf(40 + i), 1'b0);
        tick();
        m_tready_i = 1'b1;
        tick();
        m_tready_i = 1'b0;
        rstn_i     = 1'b0;
        tick();
        @(negedge clk_i);
        chk("mrst m_tvalid_o", 64'(m_tvalid_o), 64'd0);
        chk("mrst m_tdata_o",  64'(m_tdata_o),  64'd0);
        chk("mrst m_tuser_o",  64'(m_tuser_o),  64'd0);
        chk("mrst m_tlast_o",  64'(m_tlast_o),  64'd0);
        tick();
        rstn_i     = 1'b1;
        m_tready_i = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (m_tvalid_o) nv++;
            tick();
        end
        chk("post-reset idle beats", 64'(nv), 64'd0);
        strobe(mkf(50), 1'b0);
        drain("post-reset", nl);
        chk("post-reset frames out", 64'(nl), 64'd1);
        chk("model queue empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
